// File: rtl/hazard_sequencer_if.sv
// Decode-side bundle for hazard_sequencer: ID fields in, pipeline enables and scoreboard view out.
// The master modport belongs to the decode/pipeline side and the slave modport to the sequencer.
interface hazard_sequencer_if #(
  parameter int CNT_W = 16
);
  // Flow control: ID may present an instruction in any cycle (id_valid=1).
  // The instruction is consumed only in a cycle with ifid_write=1 and idex_bubble=0.
  // If ID sees ifid_write=0, it must hold the same instruction on the next cycle.
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       id_rd;
  logic             id_reg_dest;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             id_mem_write;
  logic             id_branch;
  logic             br_taken;
  logic             ext_stall;

  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             ex_valid;
  logic             ex_mem_read;
  logic             ex_reg_write;
  logic [4:0]       ex_dest;
  logic             mem_valid;
  logic             mem_reg_write;
  logic [4:0]       mem_dest;
  logic             state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_reg_dest, id_reg_write,
           id_mem_read, id_mem_write, id_branch, br_taken, ext_stall,
    input  pc_write, ifid_write, ifid_flush, idex_bubble,
           ex_valid, ex_mem_read, ex_reg_write, ex_dest,
           mem_valid, mem_reg_write, mem_dest, state, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_reg_dest, id_reg_write,
           id_mem_read, id_mem_write, id_branch, br_taken, ext_stall,
    output pc_write, ifid_write, ifid_flush, idex_bubble,
           ex_valid, ex_mem_read, ex_reg_write, ex_dest,
           mem_valid, mem_reg_write, mem_dest, state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_sequencer.sv
// Load-use / branch-wait hazard controller with a two-slot (EX, MEM) destination scoreboard.
// Optional saturating stall/flush counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  hazard_sequencer_if.slave hz
);

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_BR_WAIT = 1'b1;

  logic [0:0] state_q;
  logic [0:0] state_d;

  logic       ex_valid_q;
  logic       ex_mem_read_q;
  logic       ex_reg_write_q;
  logic [4:0] ex_dest_q;
  logic       mem_valid_q;
  logic       mem_reg_write_q;
  logic [4:0] mem_dest_q;

  logic [4:0] id_dest;
  logic       uses_rt;
  logic       rs_hit;
  logic       rt_hit;
  logic       load_use;
  logic       issue;

  assign id_dest = hz.id_reg_dest ? hz.id_rd : hz.id_rt;
  assign uses_rt = hz.id_reg_dest | hz.id_mem_write | hz.id_branch;

  // Register 0 is hardwired, so a load targeting it can never create a dependency.
  assign rs_hit   = (ex_dest_q == hz.id_rs);
  assign rt_hit   = uses_rt & (ex_dest_q == hz.id_rt);
  assign load_use = (state_q == ST_RUN) & hz.id_valid & ex_valid_q & ex_mem_read_q &
                    (ex_dest_q != 5'd0) & (rs_hit | rt_hit);
  assign issue    = (state_q == ST_RUN) & hz.id_valid & ~load_use & ~hz.ext_stall;

  always_comb begin
    hz.pc_write    = 1'b0;
    hz.ifid_write  = 1'b0;
    hz.ifid_flush  = 1'b0;
    hz.idex_bubble = 1'b1;
    if (!rst_n) begin
      hz.pc_write    = 1'b0;
      hz.ifid_write  = 1'b0;
      hz.ifid_flush  = 1'b0;
      hz.idex_bubble = 1'b1;
    end else if (hz.ext_stall) begin
      hz.pc_write    = 1'b0;
      hz.ifid_write  = 1'b0;
      hz.ifid_flush  = 1'b0;
      hz.idex_bubble = 1'b0;
    end else if (state_q == ST_BR_WAIT) begin
      hz.pc_write    = hz.br_taken;
      hz.ifid_write  = 1'b0;
      hz.ifid_flush  = hz.br_taken;
      hz.idex_bubble = 1'b1;
    end else if (load_use) begin
      hz.pc_write    = 1'b0;
      hz.ifid_write  = 1'b0;
      hz.ifid_flush  = 1'b0;
      hz.idex_bubble = 1'b1;
    end else begin
      hz.pc_write    = 1'b1;
      hz.ifid_write  = 1'b1;
      hz.ifid_flush  = 1'b0;
      hz.idex_bubble = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!hz.ext_stall) begin
      if (state_q == ST_BR_WAIT) begin
        state_d = ST_RUN;
      end else if (issue && hz.id_branch) begin
        state_d = ST_BR_WAIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // The whole scoreboard freezes with the pipeline while memory is not ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q      <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      ex_reg_write_q  <= 1'b0;
      ex_dest_q       <= 5'd0;
      mem_valid_q     <= 1'b0;
      mem_reg_write_q <= 1'b0;
      mem_dest_q      <= 5'd0;
    end else if (!hz.ext_stall) begin
      mem_valid_q     <= ex_valid_q;
      mem_reg_write_q <= ex_reg_write_q;
      mem_dest_q      <= ex_dest_q;
      if (issue) begin
        ex_valid_q     <= 1'b1;
        ex_mem_read_q  <= hz.id_mem_read;
        ex_reg_write_q <= hz.id_reg_write;
        ex_dest_q      <= id_dest;
      end else begin
        ex_valid_q     <= 1'b0;
        ex_mem_read_q  <= 1'b0;
        ex_reg_write_q <= 1'b0;
        ex_dest_q      <= 5'd0;
      end
    end
  end

  assign hz.ex_valid      = ex_valid_q;
  assign hz.ex_mem_read   = ex_mem_read_q;
  assign hz.ex_reg_write  = ex_reg_write_q;
  assign hz.ex_dest       = ex_dest_q;
  assign hz.mem_valid     = mem_valid_q;
  assign hz.mem_reg_write = mem_reg_write_q;
  assign hz.mem_dest      = mem_dest_q;
  assign hz.state         = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (load_use && !hz.ext_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if ((state_q == ST_BR_WAIT) && hz.br_taken && !hz.ext_stall &&
          (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`else
  assign hz.stall_cnt = '0;
  assign hz.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed scoreboard bench for hazard_sequencer: load-use, branch wait, ext_stall, reset, counters.
module tb_hazard_sequencer;

  localparam int CNT_W = 4;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Control vector: {pc_write, ifid_write, ifid_flush, idex_bubble, state}
  localparam logic [4:0] C_RUN     = 5'b11000;
  localparam logic [4:0] C_STALL   = 5'b00010;
  localparam logic [4:0] C_BR_T    = 5'b10111;
  localparam logic [4:0] C_BR_NT   = 5'b00011;
  localparam logic [4:0] C_FRZ_BR  = 5'b00001;
  localparam logic [4:0] C_FRZ_RUN = 5'b00000;
  localparam logic [4:0] C_RESET   = 5'b00010;

  localparam int K_NOP = 0;
  localparam int K_R   = 1;
  localparam int K_LW  = 2;
  localparam int K_SW  = 3;
  localparam int K_BEQ = 4;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   exp_stall;
  int   exp_flush;
  logic [4:0] exp_q[$];

  hazard_sequencer_if #(.CNT_W(CNT_W)) hz ();

  hazard_sequencer #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic drive(input int kind, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd);
    hz.id_valid     = (kind != K_NOP);
    hz.id_rs        = rs;
    hz.id_rt        = rt;
    hz.id_rd        = rd;
    hz.id_reg_dest  = (kind == K_R);
    hz.id_reg_write = (kind == K_R) || (kind == K_LW);
    hz.id_mem_read  = (kind == K_LW);
    hz.id_mem_write = (kind == K_SW);
    hz.id_branch    = (kind == K_BEQ);
  endtask

  task automatic nop();
    drive(K_NOP, 5'd0, 5'd0, 5'd0);
  endtask

  // Push expected controls, compare at the falling edge, then advance past the next rising edge.
  task automatic step(input string tag, input logic [4:0] exp_ctl);
    logic [4:0] got;
    logic [4:0] exp;
    exp_q.push_back(exp_ctl);
    @(negedge clk);
    got = {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_bubble, hz.state};
    exp = exp_q.pop_front();
    check(tag, {27'd0, got}, {27'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic check_ex(input string tag, input logic v, input logic [4:0] dest);
    check({tag, "_exv"}, {31'd0, hz.ex_valid}, {31'd0, v});
    check({tag, "_exd"}, {27'd0, hz.ex_dest}, {27'd0, dest});
  endtask

  task automatic bump_stall();
    if (PERF && exp_stall < 15) exp_stall++;
  endtask

  task automatic bump_flush();
    if (PERF && exp_flush < 15) exp_flush++;
  endtask

  task automatic check_cnt(input string tag);
    check({tag, "_scnt"}, {28'd0, hz.stall_cnt}, exp_stall);
    check({tag, "_fcnt"}, {28'd0, hz.flush_cnt}, exp_flush);
  endtask

  // Stimulus and scoreboard
  initial begin
    n_tests   = 0;
    n_fail    = 0;
    exp_stall = 0;
    exp_flush = 0;
    rst_n        = 1'b0;
    hz.br_taken  = 1'b0;
    hz.ext_stall = 1'b0;
    nop();

    for (int i = 0; i < 3; i++) begin
      step("rst", C_RESET);
      check_ex("rst", 1'b0, 5'd0);
      check("rst_memv", {31'd0, hz.mem_valid}, 32'd0);
    end
    check_cnt("rst");
    rst_n = 1'b1;
    step("idle", C_RUN);
    check_ex("idle", 1'b0, 5'd0);

    // lw $5 then add $6,$5,$7
    drive(K_LW, 5'd1, 5'd5, 5'd0);
    step("lw5", C_RUN);
    check_ex("lw5", 1'b1, 5'd5);
    check("lw5_mr", {31'd0, hz.ex_mem_read}, 32'd1);
    drive(K_R, 5'd5, 5'd7, 5'd6);
    step("lu_add", C_STALL);
    bump_stall();
    check_ex("lu_add", 1'b0, 5'd0);
    check("lu_memd", {27'd0, hz.mem_dest}, 32'd5);
    check("lu_memrw", {31'd0, hz.mem_reg_write}, 32'd1);
    step("add_iss", C_RUN);
    check_ex("add_iss", 1'b1, 5'd6);
    check("add_rw", {31'd0, hz.ex_reg_write}, 32'd1);
    check_cnt("lu1");

    // lw $0 then add using $0: no hazard
    drive(K_LW, 5'd1, 5'd0, 5'd0);
    step("lw0", C_RUN);
    drive(K_R, 5'd0, 5'd0, 5'd6);
    step("add0", C_RUN);
    check_ex("add0", 1'b1, 5'd6);

    // lw $5 then lw $5,0($2): rt is a destination, not a source
    drive(K_LW, 5'd1, 5'd5, 5'd0);
    step("lw5b", C_RUN);
    drive(K_LW, 5'd2, 5'd5, 5'd0);
    step("lw_rt_nosrc", C_RUN);
    // lw $8,0($5) behind that lw $5: rs hazard
    drive(K_LW, 5'd5, 5'd8, 5'd0);
    step("lw_rs", C_STALL);
    bump_stall();
    step("lw_rs_iss", C_RUN);
    check_ex("lw_rs_iss", 1'b1, 5'd8);

    // lw $5 then sw $5,0($2): rt hazard
    drive(K_LW, 5'd1, 5'd5, 5'd0);
    step("lw5c", C_RUN);
    drive(K_SW, 5'd2, 5'd5, 5'd0);
    step("sw_rt", C_STALL);
    bump_stall();
    step("sw_iss", C_RUN);

    // ALU producer never stalls
    drive(K_R, 5'd1, 5'd2, 5'd5);
    step("add5", C_RUN);
    drive(K_R, 5'd5, 5'd5, 5'd9);
    step("alu_fwd", C_RUN);

    // Taken branch
    drive(K_BEQ, 5'd1, 5'd2, 5'd0);
    step("beq_t", C_RUN);
    drive(K_R, 5'd3, 5'd4, 5'd10);
    hz.br_taken = 1'b1;
    step("brw_t", C_BR_T);
    bump_flush();
    check_ex("brw_t", 1'b0, 5'd0);
    hz.br_taken = 1'b0;
    nop();
    step("post_t", C_RUN);
    check_cnt("br_t");

    // Not-taken branch: fall-through issues next cycle
    drive(K_BEQ, 5'd1, 5'd2, 5'd0);
    step("beq_nt", C_RUN);
    drive(K_R, 5'd3, 5'd4, 5'd9);
    step("brw_nt", C_BR_NT);
    step("ft_iss", C_RUN);
    check_ex("ft_iss", 1'b1, 5'd9);

    // ext_stall during BR_WAIT
    drive(K_R, 5'd1, 5'd2, 5'd11);
    step("add11", C_RUN);
    drive(K_BEQ, 5'd3, 5'd4, 5'd0);
    step("beq_x", C_RUN);
    nop();
    hz.br_taken  = 1'b1;
    hz.ext_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step("brw_frz", C_FRZ_BR);
      check_ex("brw_frz", 1'b1, 5'd4);
      check("brw_frz_mv", {31'd0, hz.mem_valid}, 32'd1);
      check("brw_frz_md", {27'd0, hz.mem_dest}, 32'd11);
    end
    check_cnt("brw_frz");
    hz.ext_stall = 1'b0;
    step("brw_rel", C_BR_T);
    bump_flush();
    hz.br_taken = 1'b0;
    step("post_x", C_RUN);
    check_cnt("br_x");

    // Load-use and branch together: stall first, branch issues next
    drive(K_LW, 5'd1, 5'd5, 5'd0);
    step("lw5d", C_RUN);
    drive(K_BEQ, 5'd5, 5'd1, 5'd0);
    step("lu_beq", C_STALL);
    bump_stall();
    step("beq_iss", C_RUN);
    nop();
    step("beq_brw", C_BR_NT);
    step("beq_done", C_RUN);

    // ext_stall over a pending load-use: no stall counted while frozen
    drive(K_LW, 5'd1, 5'd5, 5'd0);
    step("lw5e", C_RUN);
    drive(K_R, 5'd5, 5'd7, 5'd6);
    hz.ext_stall = 1'b1;
    step("lu_frz", C_FRZ_RUN);
    check_ex("lu_frz", 1'b1, 5'd5);
    check_cnt("lu_frz");
    hz.ext_stall = 1'b0;
    step("lu_rel", C_STALL);
    bump_stall();
    step("lu_rel_iss", C_RUN);

    // 20 further load-use stalls to reach saturation
    for (int i = 0; i < 20; i++) begin
      drive(K_LW, 5'd1, 5'd12, 5'd0);
      step("sat_lw", C_RUN);
      drive(K_R, 5'd2, 5'd12, 5'd13);
      step("sat_lu", C_STALL);
      bump_stall();
      step("sat_iss", C_RUN);
    end
    check_cnt("sat");

    // Reset in the middle of BR_WAIT abandons the branch
    drive(K_BEQ, 5'd1, 5'd2, 5'd0);
    step("beq_r", C_RUN);
    nop();
    hz.br_taken = 1'b1;
    rst_n = 1'b0;
    exp_stall = 0;
    exp_flush = 0;
    step("rst_br", C_RESET);
    check_ex("rst_br", 1'b0, 5'd0);
    check_cnt("rst_br");
    hz.br_taken = 1'b0;
    rst_n = 1'b1;
    step("rst_br_run", C_RUN);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Pipeline hazard controller between the IF/ID and ID/EX registers of the five-stage MIPS core. Takes the decoded control and register fields of the instruction in ID and tracks the destinations of the instructions in EX and MEM in a two-slot scoreboard. From these it drives PC/IF-ID write enables, ID/EX bubble insertion and IF/ID flush. It handles load-use stalls, branch resolution waits and external memory stalls.

## Interface
Parameters:
- CNT_W, 16, width of the performance counters

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction (0 after flush/reset)
- id_rs, id_rt, id_rd  in  5 each  register fields from decode
- id_reg_dest, id_reg_write, id_mem_read, id_mem_write, id_branch  in  1 each  decode control bits
- br_taken  in  1  branch outcome from EX; sampled only in BR_WAIT
- ext_stall  in  1  memory not ready; freezes the whole pipeline
- pc_write  out  1  PC register load enable
- ifid_write  out  1  IF/ID register load enable
- ifid_flush  out  1  clear IF/ID to NOP
- idex_bubble  out  1  load NOP controls into ID/EX
- ex_valid, ex_mem_read, ex_reg_write  out  1 each  scoreboard EX slot
- ex_dest  out  5  scoreboard EX slot destination
- mem_valid, mem_reg_write  out  1 each; mem_dest  out  5  scoreboard MEM slot
- state  out  1  0=RUN, 1=BR_WAIT
- stall_cnt, flush_cnt  out  CNT_W  performance counters

## Operation
- Destination of ID instruction: id_reg_dest ? id_rd : id_rt. uses_rt = id_reg_dest | id_mem_write | id_branch.
- load_use = state==RUN & id_valid & ex_valid & ex_mem_read & ex_dest!=0 & (ex_dest==id_rs | (uses_rt & ex_dest==id_rt)).
- Output priority, highest first:
  - ext_stall=1: pc_write=0, ifid_write=0, idex_bubble=0, ifid_flush=0. Scoreboard, state and counters hold.
  - BR_WAIT: ifid_write=0, idex_bubble=1, pc_write=br_taken, ifid_flush=br_taken. Next state is RUN.
  - RUN & load_use: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0.
  - RUN otherwise: pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0.
- Issue is RUN & id_valid & ~load_use & ~ext_stall. Issue with id_branch=1 moves to BR_WAIT.
- Scoreboard update on every cycle without ext_stall:
  - MEM slot <= EX slot.
  - EX slot <= ID instruction on issue, with valid=1 and dest, mem_read and reg_write from decode. Otherwise the EX slot loads valid=0.
- A destination of 0 never causes a hazard. Only load-use stalls; every other RAW hazard is covered by EX forwarding.
- Load-use and branch in ID in the same cycle: the stall is taken first. The branch issues on the following cycle.

## Timing
- Control outputs are combinational from state, the scoreboard and current inputs. Scoreboard, state and counters update on the clk rising edge.
- Load-use stall lasts exactly 1 cycle. The next cycle sees ex_valid=0 and the stalled instruction issues.
- Branch issued in cycle N is resolved in cycle N+1 (BR_WAIT), so the branch penalty is 1 cycle. A taken branch adds 1 further cycle in which ID holds the flushed NOP.
- ext_stall in BR_WAIT extends BR_WAIT. br_taken is ignored until ext_stall drops.
- While rst_n=0:
  - Control outputs are forced to pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0.
  - State is RUN, all scoreboard fields are 0, and counters are 0.
- Reset asserted mid-BR_WAIT abandons the branch; the core restarts from the reset PC.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt increments in every cycle with load_use=1 and ext_stall=0.
  - flush_cnt increments in every BR_WAIT cycle with br_taken=1 and ext_stall=0.
  - Both counters saturate at all-ones.
- Not defined: the counter registers are absent and stall_cnt and flush_cnt are tied to 0.

## Test plan
- Reset with rst_n=0 for 3 cycles: pc_write=0, ifid_write=0, idex_bubble=1, state=0, ex_valid=0, counters 0. After release with id_valid=0: pc_write=1, ifid_write=1.
- lw $5 issued, then add $6,$5,$7 in ID: one cycle of pc_write=0, ifid_write=0, idex_bubble=1, then add issues. stall_cnt=1.
- lw $0 followed by add using $0: no stall. lw $5 followed by lw $8,0($5) (rt not used as a source): stall. lw $5 followed by sw $5: stall via the rt path.
- beq issued, then br_taken=1 in BR_WAIT: pc_write=1, ifid_flush=1, ifid_write=0, idex_bubble=1; state returns to 0 and flush_cnt=1. Same with br_taken=0: pc_write=0, no flush, and the fall-through instruction issues on the next cycle.
- ext_stall=1 for 2 cycles during BR_WAIT with br_taken=1: all enables 0, state stays 1 and the scoreboard is unchanged. The flush occurs on the first cycle with ext_stall=0.
- With HAZARD_PERF_CNT_EN, CNT_W=4 and 20 load-use stalls: stall_cnt=15. Without the macro: both counters read 0.
